// File: rtl/rsc_stream_encoder.sv
// LTE constituent RSC encoder emitting BPSK-mapped systematic/parity word pairs per bit.
// Define RSC_TERMINATION_EN to append the three trellis-termination steps (2K+6 words per block).
module rsc_stream_encoder #(
    parameter int W     = 16,
    parameter int AMP   = 64,
    parameter int LEN_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [LEN_W-1:0] blklen,
    output logic [W-1:0]     out,
    output logic             valid_out,
    output logic             sop_out,
    output logic             last_out
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StSys     = 3'd1;
    localparam logic [2:0] StPar     = 3'd2;
    localparam logic [2:0] StWait    = 3'd3;
`ifdef RSC_TERMINATION_EN
    localparam logic [2:0] StTailSys = 3'd4;
    localparam logic [2:0] StTailPar = 3'd5;
`endif

    localparam logic [W-1:0] Pos = W'(AMP);
    localparam logic [W-1:0] Neg = W'(-AMP);

    logic [2:0]       state_q, state_d;
    logic [2:0]       trel_q, trel_d;  // {s3, s2, s1}
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] k_q, k_d;
    logic             par_q, par_d;
    logic [W-1:0]     out_q, out_d;
    logic             valid_q, valid_d;
    logic             sop_q, sop_d;
    logic             last_q, last_d;
    logic             ready_q, ready_d;
    logic             transfer, fb, par_bit, last_bit, accept;
`ifdef RSC_TERMINATION_EN
    logic [1:0]       tail_q, tail_d;
    logic             tail_u, tail_z, tail_step;

    assign tail_u = trel_q[1] ^ trel_q[2];
    assign tail_z = trel_q[0] ^ trel_q[2];
`endif

    assign transfer = valid_in & ready_q;
    assign fb       = bit_in ^ trel_q[1] ^ trel_q[2];
    assign par_bit  = fb ^ trel_q[0] ^ trel_q[2];
    assign last_bit = (cnt_q == k_q);

    function automatic logic [W-1:0] map_bit(input logic b);
        return b ? Neg : Pos;
    endfunction

    always_comb begin
        state_d = state_q;
        trel_d  = trel_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        par_d   = par_q;
        out_d   = out_q;
        valid_d = 1'b0;
        sop_d   = 1'b0;
        last_d  = 1'b0;
        ready_d = ready_q;
        accept  = 1'b0;
`ifdef RSC_TERMINATION_EN
        tail_d    = tail_q;
        tail_step = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                // A zero block length swallows the bit without starting a block.
                if (transfer && (blklen != '0)) begin
                    accept = 1'b1;
                    k_d    = blklen;
                    cnt_d  = LEN_W'(1);
                    sop_d  = 1'b1;
                end
            end
            StSys: begin
                out_d   = map_bit(par_q);
                valid_d = 1'b1;
                ready_d = ~last_bit;
                state_d = StPar;
`ifndef RSC_TERMINATION_EN
                last_d  = last_bit;
`endif
            end
            StPar, StWait: begin
                if (transfer) begin
                    accept = 1'b1;
                    cnt_d  = cnt_q + LEN_W'(1);
                end else if ((state_q == StPar) && last_bit) begin
`ifdef RSC_TERMINATION_EN
                    tail_step = 1'b1;
                    tail_d    = 2'd0;
`else
                    state_d = StIdle;
                    trel_d  = '0;
                    ready_d = 1'b1;
`endif
                end else begin
                    state_d = StWait;
                    ready_d = 1'b1;
                end
            end
`ifdef RSC_TERMINATION_EN
            StTailSys: begin
                out_d   = map_bit(par_q);
                valid_d = 1'b1;
                last_d  = (tail_q == 2'd2);
                ready_d = 1'b0;
                state_d = StTailPar;
            end
            StTailPar: begin
                if (tail_q == 2'd2) begin
                    state_d = StIdle;
                    trel_d  = '0;
                    ready_d = 1'b1;
                end else begin
                    tail_step = 1'b1;
                    tail_d    = tail_q + 2'd1;
                end
            end
`endif
            default: begin
                state_d = StIdle;
                trel_d  = '0;
                ready_d = 1'b1;
            end
        endcase

        if (accept) begin
            trel_d  = {trel_q[1:0], fb};
            par_d   = par_bit;
            out_d   = map_bit(bit_in);
            valid_d = 1'b1;
            ready_d = 1'b0;
            state_d = StSys;
        end
`ifdef RSC_TERMINATION_EN
        // Tail input cancels the feedback, so the shift-in bit is always zero.
        if (tail_step) begin
            trel_d  = {trel_q[1:0], 1'b0};
            par_d   = tail_z;
            out_d   = map_bit(tail_u);
            valid_d = 1'b1;
            ready_d = 1'b0;
            state_d = StTailSys;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            trel_q  <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            par_q   <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef RSC_TERMINATION_EN
            tail_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            trel_q  <= trel_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            par_q   <= par_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            last_q  <= last_d;
            ready_q <= ready_d;
`ifdef RSC_TERMINATION_EN
            tail_q  <= tail_d;
`endif
        end
    end

    assign out       = out_q;
    assign valid_out = valid_q;
    assign sop_out   = sop_q;
    assign last_out  = last_q;
    assign ready_in  = ready_q;

endmodule

// File: tb/tb_rsc_stream_encoder.sv
// Randomized self-checking bench for rsc_stream_encoder against a queue-based reference model.
module tb_rsc_stream_encoder;

    localparam int W     = 16;
    localparam int AMP   = 64;
    localparam int LEN_W = 13;
`ifdef RSC_TERMINATION_EN
    localparam bit TERM = 1'b1;
`else
    localparam bit TERM = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             bit_in = 1'b0;
    logic             valid_in = 1'b0;
    logic             ready_in;
    logic [LEN_W-1:0] blklen = '0;
    logic [W-1:0]     out;
    logic             valid_out;
    logic             sop_out;
    logic             last_out;

    typedef struct {
        int word;
        bit sop;
        bit last;
        bit rdy;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   obs[$];
    int   sop_cyc[$];
    int   last_cyc[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   prev_last = 1'b0;

    bit   b_k1[$] = {1'b1};
    bit   b_k4[$] = {1'b1, 1'b0, 1'b1, 1'b1};
    bit   b_k3[$] = {1'b1, 1'b1, 1'b0};
    bit   rb[$];
    bit   rb2[$];
`ifdef RSC_TERMINATION_EN
    int   lit_k1[$] = {-64, -64, 64, -64, -64, 64, -64, -64};
    int   lit_k4[$] = {-64, -64, 64, -64, -64, 64, -64, -64, 64, 64, 64, 64, 64, 64};
`else
    int   lit_k1[$] = {-64, -64};
    int   lit_k4[$] = {-64, -64, 64, -64, -64, 64, -64, -64};
`endif

    rsc_stream_encoder #(
        .W    (W),
        .AMP  (AMP),
        .LEN_W(LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (bit_in),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .blklen   (blklen),
        .out      (out),
        .valid_out(valid_out),
        .sop_out  (sop_out),
        .last_out (last_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    function automatic int map_b(input bit b);
        return b ? -AMP : AMP;
    endfunction

    function automatic void push_exp(input int w, input bit s, input bit l, input bit r);
        exp_t e;
        e.word = w;
        e.sop  = s;
        e.last = l;
        e.rdy  = r;
        exp_q.push_back(e);
    endfunction

    // Reference encoder: shift register r[1..3] with feedback 1+D^2+D^3, parity 1+D+D^3.
    function automatic void model_block(input int k, input bit bits[$]);
        bit r[1:3];
        bit u, a, z;
        r[1] = 1'b0; r[2] = 1'b0; r[3] = 1'b0;
        for (int i = 0; i < k; i++) begin
            u = bits[i];
            a = u ^ r[2] ^ r[3];
            z = a ^ r[1] ^ r[3];
            push_exp(map_b(u), i == 0, 1'b0, 1'b0);
            push_exp(map_b(z), 1'b0, !TERM && (i == k - 1), i < k - 1);
            r[3] = r[2]; r[2] = r[1]; r[1] = a;
        end
        for (int t = 0; t < (TERM ? 3 : 0); t++) begin
            u = r[2] ^ r[3];
            z = r[1] ^ r[3];
            push_exp(map_b(u), 1'b0, 1'b0, 1'b0);
            push_exp(map_b(z), 1'b0, t == 2, 1'b0);
            r[3] = r[2]; r[2] = r[1]; r[1] = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (prev_last) chk("ready_after_last", int'(ready_in), 1);
            if (valid_out === 1'b1) begin
                obs.push_back(int'($signed(out)));
                if (sop_out) sop_cyc.push_back(cyc);
                if (last_out) last_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0d, expected no word",
                             int'($signed(out)));
                end else begin
                    cur = exp_q.pop_front();
                    chk("word", int'($signed(out)), cur.word);
                    chk("sop", int'(sop_out), int'(cur.sop));
                    chk("last", int'(last_out), int'(cur.last));
                    chk("ready_during_word", int'(ready_in), int'(cur.rdy));
                end
            end else begin
                chk("idle_sop_last", int'(sop_out | last_out), 0);
            end
            prev_last = (valid_out === 1'b1) && (last_out === 1'b1);
        end else begin
            prev_last = 1'b0;
        end
    end

    // Entered and left at a falling edge.
    task automatic send_bit(input bit b);
        int n = 0;
        bit_in   = b;
        valid_in = 1'b1;
        while (ready_in !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready_in=%0b, expected 1 within 200 cycles", ready_in);
        end
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic send_block(input int k, input bit bits[$], input int gap);
        blklen = LEN_W'(k);
        for (int i = 0; i < k; i++) begin
            send_bit(bits[i]);
            if (i == 0) blklen = LEN_W'($urandom);
            if (i < k - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_lit(input int k, input bit bits[$], input int lit[$]);
        obs.delete(); sop_cyc.delete(); last_cyc.delete();
        model_block(k, bits);
        send_block(k, bits, 0);
        drain();
        chk("lit_count", obs.size(), lit.size());
        for (int i = 0; i < obs.size() && i < lit.size(); i++) chk("lit_word", obs[i], lit[i]);
        chk("sop_count", sop_cyc.size(), 1);
        chk("last_count", last_cyc.size(), 1);
        if (sop_cyc.size() == 1 && last_cyc.size() == 1)
            chk("contiguous_span", last_cyc[0] - sop_cyc[0], lit.size() - 1);
    endtask

    initial begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_out", int'(out), 0);
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_sop", int'(sop_out), 0);
        chk("rst_last", int'(last_out), 0);
        chk("rst_ready", int'(ready_in), 1);
        rst = 1'b0;

        run_lit(1, b_k1, lit_k1);
        run_lit(4, b_k4, lit_k4);
        run_lit(1, b_k1, lit_k1);

        model_block(3, b_k3);
        send_block(3, b_k3, 0);
        drain();
        model_block(3, b_k3);
        send_block(3, b_k3, 5);
        drain();

        blklen = '0;
        send_bit(1'b1);
        repeat (10) @(negedge clk);
        chk("zero_len_ready", int'(ready_in), 1);

        rb.delete(); rb2.delete();
        for (int i = 0; i < 40; i++) begin
            rb.push_back(1'($urandom_range(0, 1)));
            rb2.push_back(1'($urandom_range(0, 1)));
        end
        obs.delete(); sop_cyc.delete(); last_cyc.delete();
        model_block(40, rb);
        model_block(40, rb2);
        send_block(40, rb, 0);
        send_block(40, rb2, 0);
        drain();
        chk("two_block_words", obs.size(), TERM ? 172 : 160);
        chk("two_block_sops", sop_cyc.size(), 2);
        if (sop_cyc.size() >= 2 && last_cyc.size() >= 1)
            chk("second_sop_cycle", sop_cyc[1] - last_cyc[0], 2);

        obs.delete();
        model_block(40, rb);
        blklen = LEN_W'(40);
        for (int i = 0; i < 3; i++) send_bit(rb[i]);
        #1;
        rst      = 1'b1;
        valid_in = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("abort_valid", int'(valid_out), 0);
        chk("abort_ready", int'(ready_in), 1);
        chk("abort_words_seen", obs.size(), 5);
        rst = 1'b0;
        @(negedge clk);
        run_lit(1, b_k1, lit_k1);

        for (int blk = 0; blk < 6; blk++) begin
            int k;
            k = $urandom_range(1, 12);
            rb.delete();
            for (int i = 0; i < k; i++) rb.push_back(1'($urandom_range(0, 1)));
            model_block(k, rb);
            send_block(k, rb, $urandom_range(0, 3));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
